// File: rtl/demux1a2_24b_round.sv
// demux1a2_24b_round
// Round-based 1-to-2 demultiplexer for the 24-bit hash datapath word stream.
// Accepted words are steered into lane A for one round of ROUND_LAST+1 words,
// then into lane B for the next round, and so on. The block also exports the
// round position (counter) and a two-cycle delayed copy (counter_2d) used by
// the downstream recombining mux.
//
// Optional feature: define DEMUX_ROUND_CNT_EN to add the 16-bit round_cnt
// output, which counts completed rounds and wraps at 16'hffff.
module demux1a2_24b_round #(
  parameter int                 WIDTH      = 24,
  parameter int                 ROUND_LAST = 33,
  parameter logic [WIDTH-1:0]   RESET_WORD = 24'hfe8901
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] A_out,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B_out,
  output logic             B_valid,
  input  logic             B_ready,
  output logic             lane,
  output logic [5:0]       counter,
  output logic [5:0]       counter_2d
`ifdef DEMUX_ROUND_CNT_EN
  ,
  output logic [15:0]      round_cnt
`endif
);

  // Index of the final word of a round, in the counter's own width.
  localparam logic [5:0] LAST_IDX = 6'(ROUND_LAST);

  logic       sel_valid_s;
  logic       sel_ready_s;
  logic       accept_s;
  logic       load_a_s;
  logic       load_b_s;
  logic       wrap_s;
  logic [5:0] cnt_d1_r;

  // Selected-lane handshake: din_ready depends only on the current lane's
  // occupancy and consumer ready, never on din_valid.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_ready_s = 1'b0;
    if (lane) begin
      sel_valid_s = A_valid;
      sel_ready_s = A_ready;
    end else begin
      sel_valid_s = B_valid;
      sel_ready_s = B_ready;
    end
    din_ready = !sel_valid_s || sel_ready_s;
    accept_s  = din_valid && din_ready;
    load_a_s  = accept_s && lane;
    load_b_s  = accept_s && !lane;
    wrap_s    = (counter == LAST_IDX);
  end

  // Lane A holding register: a load beats a same-cycle consume (no bubble);
  // a consume alone only clears valid and keeps the last word visible.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      A_out   <= RESET_WORD;
      A_valid <= 1'b0;
    end else if (load_a_s) begin
      A_out   <= din;
      A_valid <= 1'b1;
    end else if (A_valid && A_ready) begin
      A_valid <= 1'b0;
    end else begin
      A_valid <= A_valid;
    end
  end

  // Lane B holding register, same load/consume priority as lane A.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      B_out   <= RESET_WORD;
      B_valid <= 1'b0;
    end else if (load_b_s) begin
      B_out   <= din;
      B_valid <= 1'b1;
    end else if (B_valid && B_ready) begin
      B_valid <= 1'b0;
    end else begin
      B_valid <= B_valid;
    end
  end

  // Round position: advances only on accept; the last word of a round still
  // lands in the current lane and the lane flips for the following word.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      lane    <= 1'b1;
      counter <= 6'd0;
    end else if (accept_s) begin
      if (wrap_s) begin
        counter <= 6'd0;
        lane    <= !lane;
      end else begin
        counter <= counter + 6'd1;
        lane    <= lane;
      end
    end else begin
      counter <= counter;
      lane    <= lane;
    end
  end

  // Two-stage delay of the round position, shifting every cycle regardless
  // of handshake so the recombining mux sees a fixed-latency copy.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_d1_r   <= 6'd0;
      counter_2d <= 6'd0;
    end else begin
      cnt_d1_r   <= counter;
      counter_2d <= cnt_d1_r;
    end
  end

`ifdef DEMUX_ROUND_CNT_EN
  // Completed-round counter: bumps when the last word of a round is accepted,
  // wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      round_cnt <= 16'd0;
    end else if (accept_s && wrap_s) begin
      round_cnt <= round_cnt + 16'd1;
    end else begin
      round_cnt <= round_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_demux1a2_24b_round.sv
// Testbench for demux1a2_24b_round: directed vectors with literal expectations
// plus a word-count based reference model compared on every negedge.
module tb_demux1a2_24b_round;

  localparam int          ROUND_LEN = 34;
  localparam logic [23:0] RST_W     = 24'hfe8901;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [23:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [23:0] A_out;
  logic        A_valid;
  logic        A_ready;
  logic [23:0] B_out;
  logic        B_valid;
  logic        B_ready;
  logic        lane;
  logic [5:0]  counter;
  logic [5:0]  counter_2d;
`ifdef DEMUX_ROUND_CNT_EN
  logic [15:0] round_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  demux1a2_24b_round dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .A_out      (A_out),
    .A_valid    (A_valid),
    .A_ready    (A_ready),
    .B_out      (B_out),
    .B_valid    (B_valid),
    .B_ready    (B_ready),
    .lane       (lane),
    .counter    (counter),
    .counter_2d (counter_2d)
`ifdef DEMUX_ROUND_CNT_EN
    ,
    .round_cnt  (round_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The whole stream position follows from the number of words accepted
  // since reset: round = acc / ROUND_LEN, lane A on even rounds.
  bit          m_init = 1'b0;
  int          m_acc;
  logic [23:0] m_a_word;
  logic [23:0] m_b_word;
  bit          m_a_full;
  bit          m_b_full;
  logic [5:0]  m_d1;
  logic [5:0]  m_d2;

  function automatic bit m_lane_a();
    return ((m_acc / ROUND_LEN) % 2) == 0;
  endfunction

  function automatic bit m_ready();
    if (m_lane_a()) return !m_a_full || A_ready;
    else            return !m_b_full || B_ready;
  endfunction

  function automatic bit m_accept();
    return din_valid && m_ready();
  endfunction

  // Model state advance on each rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    if (!reset_L) begin
      m_init   <= 1'b1;
      m_acc    <= 0;
      m_a_word <= RST_W;
      m_b_word <= RST_W;
      m_a_full <= 1'b0;
      m_b_full <= 1'b0;
      m_d1     <= 6'd0;
      m_d2     <= 6'd0;
    end else begin
      m_d1 <= 6'(m_acc % ROUND_LEN);
      m_d2 <= m_d1;
      if (m_accept() && m_lane_a()) begin
        m_a_word <= din;
        m_a_full <= 1'b1;
      end else if (m_a_full && A_ready) begin
        m_a_full <= 1'b0;
      end
      if (m_accept() && !m_lane_a()) begin
        m_b_word <= din;
        m_b_full <= 1'b1;
      end else if (m_b_full && B_ready) begin
        m_b_full <= 1'b0;
      end
      if (m_accept()) m_acc <= m_acc + 1;
    end
  end

  // Compare DUT against the model on every falling edge once reset was seen.
  always @(negedge clk) begin
    if (m_init) begin
      check("m_A_out",      32'(A_out),      32'(m_a_word));
      check("m_A_valid",    32'(A_valid),    32'(m_a_full));
      check("m_B_out",      32'(B_out),      32'(m_b_word));
      check("m_B_valid",    32'(B_valid),    32'(m_b_full));
      check("m_lane",       32'(lane),       32'(m_lane_a()));
      check("m_counter",    32'(counter),    32'(m_acc % ROUND_LEN));
      check("m_counter_2d", 32'(counter_2d), 32'(m_d2));
      check("m_din_ready",  32'(din_ready),  32'(m_ready()));
`ifdef DEMUX_ROUND_CNT_EN
      check("m_round_cnt",  32'(round_cnt),  32'((m_acc / ROUND_LEN) % 65536));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_L   = 1'b0;
    din_valid = 1'b1;
    din       = 24'h55aa55;
    A_ready   = 1'b0;
    B_ready   = 1'b0;

    // Reset held for 3 cycles with din_valid high.
    repeat (3) tick();
    check("rst_A_out",      32'(A_out),      32'hfe8901);
    check("rst_B_out",      32'(B_out),      32'hfe8901);
    check("rst_A_valid",    32'(A_valid),    32'd0);
    check("rst_B_valid",    32'(B_valid),    32'd0);
    check("rst_lane",       32'(lane),       32'd1);
    check("rst_counter",    32'(counter),    32'd0);
    check("rst_counter_2d", 32'(counter_2d), 32'd0);
    check("rst_din_ready",  32'(din_ready),  32'd1);

    // Two full rounds streamed with both consumers ready.
    reset_L = 1'b1;
    A_ready = 1'b1;
    B_ready = 1'b1;
    for (int i = 0; i < 68; i++) begin
      din = 24'(i);
      tick();
      if (i == 0) begin
        check("stream_first_A_out",   32'(A_out),   32'd0);
        check("stream_first_A_valid", 32'(A_valid), 32'd1);
      end
      if (i == 9) begin
        check("stream_counter_10",   32'(counter),    32'd10);
        check("stream_counter_2d_8", 32'(counter_2d), 32'd8);
      end
      if (i == 33) begin
        check("stream_toggle1_lane",    32'(lane),    32'd0);
        check("stream_toggle1_counter", 32'(counter), 32'd0);
        check("stream_word33_A",        32'(A_out),   32'd33);
      end
      if (i == 34) check("stream_word34_B", 32'(B_out), 32'd34);
      if (i == 67) begin
        check("stream_toggle2_lane", 32'(lane),  32'd1);
        check("stream_word67_B",     32'(B_out), 32'd67);
      end
    end

    // Backpressure on lane A.
    din = 24'h000123;
    tick();
    check("bp_A_out_123", 32'(A_out),   32'h000123);
    check("bp_counter_1", 32'(counter), 32'd1);
    A_ready = 1'b0;
    B_ready = 1'b0;
    din     = 24'h000456;
    #1;
    check("bp_din_ready_low", 32'(din_ready), 32'd0);
    tick();
    tick();
    check("bp_counter_frozen", 32'(counter), 32'd1);
    check("bp_A_out_held",     32'(A_out),   32'h000123);
    check("bp_A_valid_held",   32'(A_valid), 32'd1);
    B_ready = 1'b1;
    #1;
    check("bp_B_ready_ignored", 32'(din_ready), 32'd0);
    tick();
    check("bp_counter_still", 32'(counter), 32'd1);
    A_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(din_ready), 32'd1);
    tick();
    check("bp_release_A_out",   32'(A_out),   32'h000456);
    check("bp_release_A_valid", 32'(A_valid), 32'd1);
    check("bp_release_counter", 32'(counter), 32'd2);

    // Boundary stall at counter == 33.
    for (int k = 0; k < 31; k++) begin
      din = 24'h000100 + 24'(k);
      tick();
    end
    check("bd_counter_33", 32'(counter), 32'd33);
    A_ready = 1'b0;
    din     = 24'habc033;
    tick();
    tick();
    check("bd_stall_counter", 32'(counter),   32'd33);
    check("bd_stall_lane",    32'(lane),      32'd1);
    check("bd_stall_ready",   32'(din_ready), 32'd0);
    A_ready = 1'b1;
    tick();
    check("bd_word33_A",    32'(A_out),   32'habc033);
    check("bd_lane_B",      32'(lane),    32'd0);
    check("bd_counter_0",   32'(counter), 32'd0);

    // Mid-round reset at counter == 17 with both lanes holding words.
    A_ready = 1'b0;
    B_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      din = 24'h000200 + 24'(k);
      tick();
    end
    B_ready   = 1'b0;
    din_valid = 1'b0;
    tick();
    check("mr_counter_17", 32'(counter), 32'd17);
    check("mr_A_valid",    32'(A_valid), 32'd1);
    check("mr_B_valid",    32'(B_valid), 32'd1);
    check("mr_B_out",      32'(B_out),   32'h000210);
    reset_L   = 1'b0;
    din_valid = 1'b1;
    tick();
    check("mr_rst_A_out",      32'(A_out),      32'hfe8901);
    check("mr_rst_B_out",      32'(B_out),      32'hfe8901);
    check("mr_rst_A_valid",    32'(A_valid),    32'd0);
    check("mr_rst_B_valid",    32'(B_valid),    32'd0);
    check("mr_rst_lane",       32'(lane),       32'd1);
    check("mr_rst_counter",    32'(counter),    32'd0);
    check("mr_rst_counter_2d", 32'(counter_2d), 32'd0);
    reset_L = 1'b1;
    A_ready = 1'b1;
    din     = 24'h00beef;
    tick();
    check("mr_restart_A_out",   32'(A_out),   32'h00beef);
    check("mr_restart_A_valid", 32'(A_valid), 32'd1);
    check("mr_restart_lane",    32'(lane),    32'd1);
    check("mr_restart_counter", 32'(counter), 32'd1);

    // Mixed valid/ready pattern across a lane toggle, checked by the model.
    for (int i = 0; i < 150; i++) begin
      din       = 24'h300000 + 24'(i);
      din_valid = (i % 3) != 2;
      A_ready   = (i % 4) != 1;
      B_ready   = ((i / 2) % 3) != 0;
      tick();
    end

    din_valid = 1'b0;
    A_ready   = 1'b1;
    B_ready   = 1'b1;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
